// File: rtl/sm_pkg.sv
// Shared definitions for the route sequencer: turn codes, FSM states and
// the legality check applied to incoming route entries.
package sm_pkg;

    localparam logic [2:0] TURN_CLEAR    = 3'd0;
    localparam logic [2:0] TURN_STRAIGHT = 3'd1;
    localparam logic [2:0] TURN_UTURN    = 3'd4;
    localparam logic [2:0] TURN_RIGHT    = 3'd5;
    localparam logic [2:0] TURN_LEFT     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    function automatic logic isLegalCode(input logic [2:0] code);
        return (code == TURN_CLEAR) || (code == TURN_STRAIGHT) ||
               (code == TURN_UTURN) || (code == TURN_RIGHT)    ||
               (code == TURN_LEFT);
    endfunction

endpackage

// File: rtl/sm_route_sequencer_if.sv
// Valid/ready stream carrying route entries from the UART path planner.
interface sm_route_sequencer_if;

    logic       load_valid;
    logic       load_ready;
    logic [2:0] load_code;
    logic       load_last;

    modport master (output load_valid, load_code, load_last, input load_ready);
    modport slave  (input load_valid, load_code, load_last, output load_ready);

endinterface

// File: rtl/sm_route_mem.sv
// Route storage: DEPTH x 3 register file, synchronous write, asynchronous read.
module sm_route_mem #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [2:0]       wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [2:0]       rdata_o
);

    logic [2:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sm_route_sequencer.sv
// Feeds one stored turn code to the line follower per detected node and
// flags taskend once the route is exhausted.
module sm_route_sequencer
    import sm_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int IDX_W       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sm_route_sequencer_if.slave  load,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [4:0]           node_count_i,
    output logic [2:0]           turn_o,
    output logic                 taskend_o,
    output logic [IDX_W-1:0]     route_idx_o,
    output logic                 busy_o,
    output logic                 error_o
);

    localparam int               HCW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);
    localparam logic [HCW-1:0]   HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] wrPtr_q,    wrPtr_d;
    logic [IDX_W:0]   len_q,      len_d;
    logic [IDX_W:0]   routeIdx_q, routeIdx_d;
    logic [4:0]       nodeCnt_q,  nodeCnt_d;
    logic [HCW-1:0]   holdCnt_q,  holdCnt_d;
    logic [2:0]       turn_q,     turn_d;
    logic             taskend_q,  taskend_d;
    logic             error_q,    error_d;

    logic             loadReady;
    logic             loadFire;
    logic             memWe;
    logic             nodeEvent;
    logic [IDX_W-1:0] memWaddr;
    logic [2:0]       memRdata;

    assign loadReady = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign loadFire  = load.load_valid && loadReady && !abort_i;
    // A reload after a finished route always restarts at slot 0.
    assign memWaddr  = (state_q == ST_DONE) ? '0 : wrPtr_q;
    assign nodeEvent = (node_count_i != nodeCnt_q);

    sm_route_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (memWe),
        .waddr_i (memWaddr),
        .wdata_i (load.load_code),
        .raddr_i (routeIdx_q[IDX_W-1:0]),
        .rdata_o (memRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wrPtr_q    <= '0;
            len_q      <= '0;
            routeIdx_q <= '0;
            nodeCnt_q  <= '0;
            holdCnt_q  <= '0;
            turn_q     <= TURN_CLEAR;
            taskend_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            len_q      <= len_d;
            routeIdx_q <= routeIdx_d;
            nodeCnt_q  <= nodeCnt_d;
            holdCnt_q  <= holdCnt_d;
            turn_q     <= turn_d;
            taskend_q  <= taskend_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        len_d      = len_q;
        routeIdx_d = routeIdx_q;
        nodeCnt_d  = nodeCnt_q;
        holdCnt_d  = holdCnt_q;
        turn_d     = turn_q;
        taskend_d  = taskend_q;
        error_d    = error_q;
        memWe      = 1'b0;

        if (abort_i) begin
            state_d    = ST_IDLE;
            turn_d     = TURN_CLEAR;
            routeIdx_d = '0;
            wrPtr_d    = '0;
            len_d      = '0;
            taskend_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (loadFire) begin
                        if (!isLegalCode(load.load_code)) begin
                            error_d = 1'b1;
                        end else begin
                            memWe     = 1'b1;
                            taskend_d = 1'b0;
                            wrPtr_d   = memWaddr + 1'b1;
                            state_d   = ST_IDLE;
                            if (load.load_last || (memWaddr == LAST_ADDR)) begin
                                len_d   = {1'b0, memWaddr} + 1'b1;
                                state_d = ST_ARMED;
                                if (!load.load_last) begin
                                    error_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_ARMED: begin
                    if (start_i) begin
                        nodeCnt_d  = node_count_i;
                        routeIdx_d = '0;
                        turn_d     = TURN_STRAIGHT;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (nodeEvent) begin
                        nodeCnt_d = node_count_i;
                        if (routeIdx_q == len_q) begin
                            taskend_d = 1'b1;
                            turn_d    = TURN_CLEAR;
                            state_d   = ST_DONE;
                        end else begin
                            turn_d     = memRdata;
                            routeIdx_d = routeIdx_q + 1'b1;
                            holdCnt_d  = HOLD_LOAD;
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Resampling the counter on exit swallows nodes seen while holding.
                    if (holdCnt_q == '0) begin
                        turn_d    = TURN_STRAIGHT;
                        nodeCnt_d = node_count_i;
                        state_d   = ST_RUN;
                    end else begin
                        holdCnt_d = holdCnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign load.load_ready = loadReady;
    assign turn_o          = turn_q;
    assign taskend_o       = taskend_q;
    assign route_idx_o     = routeIdx_q[IDX_W-1:0];
    assign busy_o          = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign error_o         = error_q;

endmodule

// File: tb/tb_sm_route_sequencer.sv
// Scoreboard bench for sm_route_sequencer: stimulus pushes expected issues,
// a negedge monitor pops and checks them as the DUT presents them.
module tb_sm_route_sequencer;

    localparam int DEPTH = 16;
    localparam int HOLD  = 8;
    localparam int IDX_W = 4;
    localparam int END_MARK = -1;

    typedef struct {
        int code;
        int idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [4:0]       nodeCount = 5'd0;
    logic [2:0]       turn;
    logic             taskend;
    logic [IDX_W-1:0] routeIdx;
    logic             busy;
    logic             error;

    sm_route_sequencer_if lif ();

    sm_route_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .IDX_W       (IDX_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (lif.slave),
        .start_i      (start),
        .abort_i      (abort),
        .node_count_i (nodeCount),
        .turn_o       (turn),
        .taskend_o    (taskend),
        .route_idx_o  (routeIdx),
        .busy_o       (busy),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t expQ[$];
    int   route[$];
    int   issued = 0;
    bit   modelError = 0;
    int   legalCodes[5] = '{0, 1, 4, 5, 6};

    int   cyc = 0;
    int   changeCyc = -100;
    bit   holdCancel = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, $signed(actual), $signed(expected));
        end
    endtask

    // Monitor: recognise issues (route_idx steps while busy) and taskend rises.
    logic [IDX_W-1:0] prevIdx = '0;
    logic             prevBusy = 1'b0;
    logic             prevTaskend = 1'b0;
    int               holdLeft = 0;
    logic [2:0]       heldCode = '0;
    bit               holdOk = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prevIdx     = '0;
            prevBusy    = 1'b0;
            prevTaskend = 1'b0;
            holdLeft    = 0;
        end else begin
            if (holdCancel) holdLeft = 0;
            if (holdLeft > 1) begin
                if (turn !== heldCode) holdOk = 1'b0;
                holdLeft--;
            end else if (holdLeft == 1) begin
                checkOutput("holdKept", 32'(holdOk), 1);
                checkOutput("holdRelease", 32'(turn), 1);
                holdLeft = 0;
            end
            if (busy && prevBusy && (routeIdx !== prevIdx)) begin
                checkOutput("issueQueued", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("issueCode", 32'(turn), 32'(e.code[2:0]));
                    checkOutput("issueIdx", 32'(routeIdx), 32'((e.idx + 1) % DEPTH));
                    checkOutput("issueLatency", 32'(cyc - changeCyc), 1);
                    checkOutput("issueNotEnd", 32'(e.code), 32'(e.code >= 0 ? e.code : 99));
                    heldCode = turn;
                    holdOk   = 1'b1;
                    holdLeft = HOLD;
                end
            end
            if (taskend && !prevTaskend) begin
                checkOutput("taskendQueued", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("taskendMarker", 32'(e.code), 32'(END_MARK));
                    checkOutput("taskendTurn", 32'(turn), 0);
                    checkOutput("taskendLatency", 32'(cyc - changeCyc), 1);
                end
            end
            prevIdx     = routeIdx;
            prevBusy    = busy;
            prevTaskend = taskend;
        end
    end

    task automatic loadEntry(input logic [2:0] code, input bit last);
        @(posedge clk); #1;
        lif.load_valid = 1'b1;
        lif.load_code  = code;
        lif.load_last  = last;
        @(posedge clk); #1;
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
        if (int'(code) inside {0, 1, 4, 5, 6}) begin
            route.push_back(int'(code));
            if (route.size() == DEPTH && !last) modelError = 1'b1;
        end else begin
            modelError = 1'b1;
        end
    endtask

    task automatic startRoute();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        issued = 0;
        repeat (2) @(posedge clk);
    endtask

    // One node burst: the counter moves by step; optionally a second move
    // lands inside the hold window and must be swallowed.
    task automatic applyStimulus(input int step, input bit absorb, input int settle);
        @(posedge clk); #1;
        nodeCount = nodeCount + 5'(step);
        changeCyc = cyc;
        if (issued < route.size()) expQ.push_back('{route[issued], issued});
        else                       expQ.push_back('{END_MARK, issued});
        issued++;
        if (absorb) begin
            repeat (3) @(posedge clk);
            #1;
            nodeCount = nodeCount + 5'd1;
        end
        repeat (settle) @(posedge clk);
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        expQ.delete();
        route.delete();
        issued = 0;
        modelError = 1'b0;
    endtask

    initial begin
        int len;
        lif.load_valid = 1'b0;
        lif.load_code  = 3'd0;
        lif.load_last  = 1'b0;

        #12;
        checkOutput("rstTurn", 32'(turn), 0);
        checkOutput("rstTaskend", 32'(taskend), 0);
        checkOutput("rstReady", 32'(lif.load_ready), 1);
        checkOutput("rstIdx", 32'(routeIdx), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstError", 32'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed route 5,6,4");
        loadEntry(3'd5, 1'b0);
        loadEntry(3'd6, 1'b0);
        loadEntry(3'd4, 1'b1);
        checkOutput("armedReady", 32'(lif.load_ready), 0);
        startRoute();
        checkOutput("runStraight", 32'(turn), 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, HOLD + 4);
        checkOutput("doneTaskend", 32'(taskend), 1);
        checkOutput("doneBusy", 32'(busy), 0);
        checkOutput("doneReady", 32'(lif.load_ready), 1);
        checkOutput("doneError", 32'(error), 0);
        checkOutput("drained1", 32'(expQ.size()), 0);

        $display("[TB] illegal code and multi-step node change");
        route.delete();
        loadEntry(3'd3, 1'b0);
        checkOutput("illegalError", 32'(error), 32'(modelError));
        checkOutput("illegalReady", 32'(lif.load_ready), 1);
        loadEntry(3'd6, 1'b1);
        nodeCount = 5'd2;
        startRoute();
        applyStimulus(3, 1'b0, HOLD + 4);
        applyStimulus(1, 1'b0, HOLD + 4);
        checkOutput("drained2", 32'(expQ.size()), 0);

        doReset();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("idleStartIgnored", 32'(busy), 0);

        $display("[TB] random routes");
        for (int r = 0; r < 4; r++) begin
            route.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                loadEntry(3'(legalCodes[$urandom_range(0, 4)]), i == len - 1);
            checkOutput("randError", 32'(error), 32'(modelError));
            if (r == 1) nodeCount = 5'd31;
            startRoute();
            for (int i = 0; i <= len; i++)
                applyStimulus((r == 1 && i == 0) ? 1 : int'($urandom_range(1, 4)),
                              bit'($urandom_range(0, 1)), HOLD + 4);
            checkOutput("randTaskend", 32'(taskend), 1);
            checkOutput("randDrained", 32'(expQ.size()), 0);
        end

        $display("[TB] full route without last");
        route.delete();
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("fullReadyDuring", 32'(lif.load_ready), 1);
            loadEntry(3'(legalCodes[$urandom_range(0, 4)]), 1'b0);
        end
        checkOutput("fullReady", 32'(lif.load_ready), 0);
        checkOutput("fullError", 32'(error), 32'(modelError));
        startRoute();
        for (int i = 0; i <= DEPTH; i++) applyStimulus(int'($urandom_range(1, 2)), 1'b0, HOLD + 4);
        checkOutput("fullTaskend", 32'(taskend), 1);
        checkOutput("fullDrained", 32'(expQ.size()), 0);

        $display("[TB] abort during hold");
        route.delete();
        for (int i = 0; i < 5; i++) loadEntry(3'd5, i == 4);
        startRoute();
        applyStimulus(1, 1'b0, HOLD + 4);
        applyStimulus(1, 1'b0, 2);
        #1;
        holdCancel = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abortTurn", 32'(turn), 0);
        checkOutput("abortIdx", 32'(routeIdx), 0);
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortReady", 32'(lif.load_ready), 1);
        checkOutput("abortTaskend", 32'(taskend), 0);
        checkOutput("abortErrorKept", 32'(error), 32'(modelError));
        checkOutput("abortDrained", 32'(expQ.size()), 0);
        @(posedge clk); #1;
        holdCancel = 1'b0;

        $display("[TB] async reset mid-run");
        route.delete();
        for (int i = 0; i < 4; i++) loadEntry(3'd4, i == 3);
        startRoute();
        applyStimulus(1, 1'b0, HOLD + 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arstTurn", 32'(turn), 0);
        checkOutput("arstTaskend", 32'(taskend), 0);
        checkOutput("arstReady", 32'(lif.load_ready), 1);
        checkOutput("arstIdx", 32'(routeIdx), 0);
        checkOutput("arstBusy", 32'(busy), 0);
        checkOutput("arstError", 32'(error), 0);
        checkOutput("arstDrained", 32'(expQ.size()), 0);
        expQ.delete();
        route.delete();
        modelError = 1'b0;
        #3;
        rst_n = 1'b1;

        route.delete();
        loadEntry(3'd6, 1'b1);
        startRoute();
        applyStimulus(2, 1'b0, HOLD + 4);
        applyStimulus(1, 1'b0, HOLD + 4);
        checkOutput("postRstTaskend", 32'(taskend), 1);
        checkOutput("postRstDrained", 32'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_route_sequencer.md
Name: sm_route_sequencer

Overview:
- Sequences turn commands into the black-line-following block, one route entry per detected node.
- Stores a route of 3-bit turn codes loaded from the UART path-planner side through a valid/ready stream.
- After start, issues the next code on each change of the follower's node counter and raises taskend after the last node.
- Sits between the UART receiver/planner and the line-following block; it drives that block's turn and taskend inputs.

Parameters:
- DEPTH, 16: maximum route entries. Power of 2, at least 2.
- HOLD_CYCLES, 8: cycles a turn code is held after issue before reverting to STRAIGHT. Must be at least 4 to cover the follower's sync window.
- IDX_W, $clog2(DEPTH): index width.

Ports:
- clk, input, 1: 3.125 MHz ADC clock shared with the follower.
- rst_n, input, 1: asynchronous active-low reset.
- load_valid, input, 1: route entry valid.
- load_ready, output, 1: sequencer accepts an entry.
- load_code, input, 3: turn code.
- load_last, input, 1: marks the final entry of the route.
- start, input, 1: begin execution. Tied to the UART rxdone.
- abort, input, 1: synchronous abort to IDLE.
- node_count, input, 5: follower's nodesdetected counter.
- turn, output, 3: turn command to the follower.
- taskend, output, 1: route complete. Sticky until reload or abort.
- route_idx, output, IDX_W: index of the next entry to issue.
- busy, output, 1: state is RUN or HOLD.
- error, output, 1: sticky. Set on an illegal code or on overflow.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - turn = 0 (CLEAR). Code 0 makes the follower zero its node count.
  - taskend = 0, load_ready = 1, route_idx = 0, busy = 0, error = 0.
  - Write pointer = 0, length = 0, node_count_q = 0, state = IDLE.
- Turn codes:
  - 0 CLEAR, 1 STRAIGHT, 4 UTURN, 5 RIGHT, 6 LEFT.
  - Codes 2, 3 and 7 are illegal: on load, set error, discard the entry, keep load_ready high.
- Load:
  - A transfer happens when load_valid and load_ready are both high.
  - Each transfer writes mem[wptr], then wptr++.
  - load_last, or wptr reaching DEPTH-1, sets length = wptr+1, drops load_ready and moves to ARMED.
  - A write while full is impossible because load_ready is low. The write that fills the last slot without load_last sets error. The route is still usable.
  - Loading is allowed only in IDLE or DONE. The first write from DONE clears taskend and resets wptr.
- States:
  - IDLE: turn = CLEAR. Loading in progress.
  - ARMED: turn = CLEAR.
    - On start: node_count_q <= node_count, route_idx <= 0, turn <= STRAIGHT, go to RUN. Issuing starts next cycle.
    - start in IDLE with length 0 is ignored.
  - RUN: node event is node_count != node_count_q, detected with a registered compare (1-cycle latency).
    - On an event: node_count_q <= node_count, turn <= mem[route_idx], route_idx++, go to HOLD.
    - A multi-step counter change counts as one event (one entry consumed).
    - If route_idx == length at the event: taskend <= 1, turn <= CLEAR, go to DONE.
  - HOLD: count down HOLD_CYCLES. turn is held constant.
    - At 0: turn <= STRAIGHT, go to RUN.
    - Node events arriving during HOLD are not consumed. node_count_q updates at HOLD exit, so the follower's node debounce absorbs them.
  - DONE: turn = CLEAR, taskend = 1, load_ready = 1.
- Abort: from any state, next cycle go to IDLE. turn = CLEAR, route_idx = 0, wptr = 0, length = 0, taskend = 0. error is kept.
- Simultaneous events:
  - abort + start: abort wins.
  - abort + load transfer: the transfer is dropped.
  - start in RUN/HOLD/DONE is ignored.
- Reset mid-route returns everything to reset values. Memory contents need no reset.
- Counter wrap: node_count wrapping 31->0 is a change and counts as an event.

Decomposition:
- Shared package sm_pkg holds:
  - Turn-code localparams (TURN_CLEAR/STRAIGHT/UTURN/RIGHT/LEFT).
  - The state enum.
  - The legal-code check function.
- One sub-module: sm_route_mem. DEPTH x 3 register file, one synchronous write port and one asynchronous read port, no reset.
- The FSM, node-edge detect and hold counter stay in the top module.

Test Plan:
1. Load codes 5, 6, 4 with last on 4, then start.
   - Step node_count 0->1->2->3, each step after at least HOLD_CYCLES.
   - Expect turn = 5, 6, 4, each for exactly 8 cycles, starting 1 cycle after the change, with 1 between.
   - Expect taskend = 1 after a 4th change.
2. load_code = 3 -> error = 1, entry discarded, wptr unchanged, load_ready stays 1.
3. Load 16 entries with no last.
   - Expect load_ready = 0 after the 16th, error = 1, length = 16.
   - Start + 16 node events issue all entries in order.
4. node_count changes 2->5 in one cycle -> exactly one entry consumed, route_idx +1.
5. Assert abort during HOLD with route_idx = 2.
   - Next cycle: turn = 0, route_idx = 0, busy = 0, load_ready = 1.
6. Assert rst_n low asynchronously mid-RUN.
   - All outputs reach reset values before the next clk edge; error clears.
